serial_sub: RTL

Bit-serial N-bit unsigned subtractor, LSB first, one bit per clock.
- Datapath: one half-subtractor-style difference/borrow cell per bit slot, extended with a registered borrow (full-subtract per bit).
- Sits downstream of operand registers. Hands a parallel difference and final borrow to consumers through a start/busy/done handshake.
- Trades latency for area against a ripple subtractor.

---
 rtl/serial_sub.sv | 98 +++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtract bit per clock, LSB first,
// publishing a parallel difference and final borrow through start/busy/done.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic ai;
  logic bi;
  logic d;
  logic bout;
  logic last;

  assign ai   = sa[0];
  assign bi   = sb[0];
  assign d    = ai ^ bi ^ br;
  assign bout = (~ai & bi) | (~(ai ^ bi) & br);
  assign last = (cnt == CW'(WIDTH - 1));

  // Handshake: start is taken only on an edge seen in IDLE (no queueing);
  // busy is high for the WIDTH shift cycles, then done pulses for one cycle
  // while diff/borrow carry the new result, which they hold until the next one.
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          sd <= {d, sd[WIDTH-1:1]};
          br <= bout;
          if (last) begin
            // Publish including the bit produced in this final cycle.
            diff   <= {d, sd[WIDTH-1:1]};
            borrow <= bout;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
